// File: rtl/rv_exec_datapath.sv
`default_nettype none
// ============================================================================
// Module   : rv_exec_datapath
// Brief    : Single-cycle RV32I execute / write-back slice (regfile, ALU, DM).
// Revision : 1.0  initial release
// ============================================================================

module rv_exec_datapath #(
    parameter  int DM_WORDS = 32,
    localparam int DM_AW    = $clog2(DM_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       read_reg_num1,
    input  logic [4:0]       read_reg_num2,
    input  logic [4:0]       write_reg_num,
    input  logic             reg_write,
    input  logic [5:0]       alu_cntrl,
    input  logic [31:0]      imm_val,
    input  logic [4:0]       shamt,
    input  logic             mem_to_reg,
    input  logic             sw,
    input  logic             lui_cntrl,
    input  logic [31:0]      imm_val_lui,
    input  logic             jump,
    input  logic [31:0]      return_address,
    input  logic             beq_cntrl,
    input  logic             bneq_cntrl,
    input  logic             bgeq_cntrl,
    input  logic             blt_cntrl,
    output logic [DM_AW-1:0] read_data_addr_dm,
    output logic             beq,
    output logic             bneq,
    output logic             bgeq,
    output logic             blt
);

    localparam logic [4:0] c_OP_ADD  = 5'h01;
    localparam logic [4:0] c_OP_SUB  = 5'h02;
    localparam logic [4:0] c_OP_SLL  = 5'h03;
    localparam logic [4:0] c_OP_SLT  = 5'h04;
    localparam logic [4:0] c_OP_SLTU = 5'h05;
    localparam logic [4:0] c_OP_XOR  = 5'h06;
    localparam logic [4:0] c_OP_SRL  = 5'h07;
    localparam logic [4:0] c_OP_SRA  = 5'h08;
    localparam logic [4:0] c_OP_OR   = 5'h09;
    localparam logic [4:0] c_OP_AND  = 5'h0A;
    localparam logic [4:0] c_OP_EQ   = 5'h0B;
    localparam logic [4:0] c_OP_NE   = 5'h0C;
    localparam logic [4:0] c_OP_GE   = 5'h0D;
    localparam logic [4:0] c_OP_LT   = 5'h0E;

    logic [31:0]      rf_q [32];
    logic [31:0]      rf_d [32];
    logic [31:0]      dm_q [DM_WORDS];
    logic [31:0]      dm_d [DM_WORDS];

    logic [31:0]      w_rs1_data;
    logic [31:0]      w_rs2_data;
    logic [31:0]      w_alu_b;
    logic [4:0]       w_shift;
    logic [31:0]      w_alu_result;
    logic             w_result_one;
    logic [DM_AW-1:0] w_dm_idx;
    logic [31:0]      w_dm_rdata;
    logic [31:0]      w_wb_data;
    logic             w_rf_we;
    logic             w_dm_we;

    // ------------------------------------------------------------------
    // Register read: combinational, x0 hard-wired to zero, no bypass.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs1_data = (read_reg_num1 == 5'd0) ? 32'd0 : rf_q[read_reg_num1];
        w_rs2_data = (read_reg_num2 == 5'd0) ? 32'd0 : rf_q[read_reg_num2];
    end

    always_comb begin
        w_alu_b = alu_cntrl[5] ? imm_val : w_rs2_data;
        w_shift = alu_cntrl[5] ? shamt   : w_alu_b[4:0];
    end

    // ------------------------------------------------------------------
    // ALU: wrapping arithmetic, compares produce 0/1, unknown opcodes 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_result = 32'd0;
        case (alu_cntrl[4:0])
            c_OP_ADD:  w_alu_result = w_rs1_data + w_alu_b;
            c_OP_SUB:  w_alu_result = w_rs1_data - w_alu_b;
            c_OP_SLL:  w_alu_result = w_rs1_data << w_shift;
            c_OP_SLT:  w_alu_result = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
            c_OP_SLTU: w_alu_result = {31'd0, w_rs1_data < w_alu_b};
            c_OP_XOR:  w_alu_result = w_rs1_data ^ w_alu_b;
            c_OP_SRL:  w_alu_result = w_rs1_data >> w_shift;
            c_OP_SRA:  w_alu_result = $signed(w_rs1_data) >>> w_shift;
            c_OP_OR:   w_alu_result = w_rs1_data | w_alu_b;
            c_OP_AND:  w_alu_result = w_rs1_data & w_alu_b;
            c_OP_EQ:   w_alu_result = {31'd0, w_rs1_data == w_alu_b};
            c_OP_NE:   w_alu_result = {31'd0, w_rs1_data != w_alu_b};
            c_OP_GE:   w_alu_result = {31'd0, $signed(w_rs1_data) >= $signed(w_alu_b)};
            c_OP_LT:   w_alu_result = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
            default:   w_alu_result = 32'd0;
        endcase
    end

    always_comb begin
        w_result_one = (w_alu_result == 32'd1);
        beq          = beq_cntrl  & w_result_one;
        bneq         = bneq_cntrl & w_result_one;
        bgeq         = bgeq_cntrl & w_result_one;
        blt          = blt_cntrl  & w_result_one;
    end

    // ------------------------------------------------------------------
    // Data memory: word index wraps modulo the memory depth.
    // ------------------------------------------------------------------
    always_comb begin
        w_dm_idx          = DM_AW'(w_rs1_data + imm_val);
        w_dm_rdata        = dm_q[w_dm_idx];
        read_data_addr_dm = w_dm_idx;
    end

    always_comb begin
        if (jump) begin
            w_wb_data = return_address;
        end else if (lui_cntrl) begin
            w_wb_data = imm_val_lui;
        end else if (mem_to_reg) begin
            w_wb_data = w_dm_rdata;
        end else begin
            w_wb_data = w_alu_result;
        end
    end

    always_comb begin
        w_rf_we = reg_write & ~sw & (write_reg_num != 5'd0);
        w_dm_we = sw;
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (w_rf_we) begin
            rf_d[write_reg_num] = w_wb_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DM_WORDS; i++) begin
            dm_d[i] = dm_q[i];
        end
        if (w_dm_we) begin
            dm_d[w_dm_idx] = w_rs2_data;
        end
    end

    // Active-low asynchronous clear; holding reset low also blocks writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= dm_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_exec_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_exec_datapath
// Brief    : Self-checking bench; registers are observed through EQ-vs-imm.
// Revision : 1.0  initial release
// ============================================================================

module tb_rv_exec_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg_num, shamt;
    logic        reg_write, mem_to_reg, sw, lui_cntrl, jump;
    logic [5:0]  alu_cntrl;
    logic [31:0] imm_val, imm_val_lui, return_address;
    logic        beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl;
    logic [4:0]  read_data_addr_dm;
    logic        beq, bneq, bgeq, blt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rf [32];
    logic [31:0] m_dm [32];

    always #5 clk = ~clk;

    rv_exec_datapath #(.DM_WORDS(32)) dut (
        .clk(clk), .reset(reset),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg_num(write_reg_num), .reg_write(reg_write),
        .alu_cntrl(alu_cntrl), .imm_val(imm_val), .shamt(shamt),
        .mem_to_reg(mem_to_reg), .sw(sw), .lui_cntrl(lui_cntrl),
        .imm_val_lui(imm_val_lui), .jump(jump), .return_address(return_address),
        .beq_cntrl(beq_cntrl), .bneq_cntrl(bneq_cntrl),
        .bgeq_cntrl(bgeq_cntrl), .blt_cntrl(blt_cntrl),
        .read_data_addr_dm(read_data_addr_dm),
        .beq(beq), .bneq(bneq), .bgeq(bgeq), .blt(blt)
    );

    // Reference ALU written straight from the opcode table.
    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] r2v, input logic [31:0] imm,
                                            input logic [4:0] sh);
        logic [31:0] b;
        logic [4:0]  s;
        b = op[5] ? imm : r2v;
        s = op[5] ? sh : b[4:0];
        case (op[4:0])
            5'h01: return a + b;
            5'h02: return a - b;
            5'h03: return a << s;
            5'h04: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h05: return (a < b) ? 32'd1 : 32'd0;
            5'h06: return a ^ b;
            5'h07: return a >> s;
            5'h08: return 32'($signed(a) >>> s);
            5'h09: return a | b;
            5'h0A: return a & b;
            5'h0B: return (a == b) ? 32'd1 : 32'd0;
            5'h0C: return (a != b) ? 32'd1 : 32'd0;
            5'h0D: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            5'h0E: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        read_reg_num1 = 5'd0; read_reg_num2 = 5'd0; write_reg_num = 5'd0;
        reg_write = 1'b0; alu_cntrl = 6'd0; imm_val = 32'd0; shamt = 5'd0;
        mem_to_reg = 1'b0; sw = 1'b0; lui_cntrl = 1'b0; imm_val_lui = 32'd0;
        jump = 1'b0; return_address = 32'd0;
        beq_cntrl = 1'b0; bneq_cntrl = 1'b0; bgeq_cntrl = 1'b0; blt_cntrl = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wb(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_rf[rd] = v;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'd0;
            m_dm[i] = 32'd0;
        end
    endtask

    // Sets up an EQ-against-immediate so beq reports whether reg r holds v.
    task automatic probe(input logic [4:0] r, input logic [31:0] v);
        idle();
        read_reg_num1 = r; alu_cntrl = 6'h2B; imm_val = v; beq_cntrl = 1'b1;
        #1;
    endtask

    task automatic set_reg(input logic [4:0] rd, input logic [31:0] v);
        idle();
        lui_cntrl = 1'b1; imm_val_lui = v; reg_write = 1'b1; write_reg_num = rd;
        tick();
        model_wb(rd, v);
    endtask

    task automatic do_alu(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [4:0] sh);
        logic [31:0] res;
        idle();
        alu_cntrl = op; read_reg_num1 = r1; read_reg_num2 = r2; write_reg_num = rd;
        imm_val = imm; shamt = sh; reg_write = 1'b1;
        res = ref_alu(op, m_rf[r1], m_rf[r2], imm, sh);
        tick();
        model_wb(rd, res);
    endtask

    task automatic do_sw(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] imm,
                         input logic [4:0] rd);
        logic [31:0] a;
        idle();
        alu_cntrl = 6'h21; read_reg_num1 = r1; read_reg_num2 = r2; imm_val = imm;
        sw = 1'b1; reg_write = 1'b1; write_reg_num = rd;
        a = m_rf[r1] + imm;
        tick();
        m_dm[a[4:0]] = m_rf[r2];
    endtask

    task automatic do_lw(input logic [4:0] r1, input logic [31:0] imm, input logic [4:0] rd);
        logic [31:0] a;
        idle();
        alu_cntrl = 6'h21; read_reg_num1 = r1; imm_val = imm;
        mem_to_reg = 1'b1; reg_write = 1'b1; write_reg_num = rd;
        a = m_rf[r1] + imm;
        tick();
        model_wb(rd, m_dm[a[4:0]]);
    endtask

    task automatic test_reset();
        logic [4:0] regs [4];
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd17; regs[3] = 5'd31;
        idle();
        reset = 1'b0;
        clear_model();
        #3;
        foreach (regs[i]) begin
            probe(regs[i], 32'd0);
            n_cmp++;
            if (beq !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_reg x%0d: eq-probe beq=%b, required 1 (value 0)", regs[i], beq);
            end
        end
        idle();
        read_reg_num1 = 5'd0; alu_cntrl = 6'h2B; imm_val = 32'd0; beq_cntrl = 1'b0;
        #1;
        n_cmp++;
        if (beq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flag_no_strobe: beq=%b, required 0", beq);
        end
        // Write attempted while reset is held low must be lost.
        idle();
        lui_cntrl = 1'b1; imm_val_lui = 32'hCAFE0000; reg_write = 1'b1; write_reg_num = 5'd5;
        tick();
        probe(5'd5, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_write_blocked: x5 eq-0 probe beq=%b, required 1", beq);
        end
        reset = 1'b1;
        do_lw(5'd0, 32'd7, 5'd6);
        probe(5'd6, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_dm_zero: x6 eq-0 probe beq=%b, required 1", beq);
        end
    endtask

    task automatic test_alu_directed();
        logic [4:0]  rds [7];
        logic [31:0] exps [7];
        do_alu(6'h21, 5'd0, 5'd0, 5'd1, 32'd5, 5'd0);
        do_alu(6'h01, 5'd1, 5'd1, 5'd2, 32'd0, 5'd0);
        do_alu(6'h21, 5'd0, 5'd0, 5'd0, 32'd7, 5'd0);
        set_reg(5'd3, 32'd3);
        set_reg(5'd5, 32'd5);
        do_alu(6'h02, 5'd3, 5'd5, 5'd6, 32'd0, 5'd0);
        set_reg(5'd7, 32'h80000000);
        do_alu(6'h28, 5'd7, 5'd0, 5'd8, 32'd0, 5'd4);
        do_alu(6'h27, 5'd7, 5'd0, 5'd19, 32'd0, 5'd4);
        do_alu(6'h21, 5'd0, 5'd0, 5'd9, 32'hFFFFFFFF, 5'd0);
        do_alu(6'h21, 5'd0, 5'd0, 5'd10, 32'd1, 5'd0);
        do_alu(6'h04, 5'd9, 5'd10, 5'd17, 32'd0, 5'd0);
        do_alu(6'h05, 5'd9, 5'd10, 5'd18, 32'd0, 5'd0);
        rds[0] = 5'd1;  exps[0] = 32'd5;
        rds[1] = 5'd2;  exps[1] = 32'd10;
        rds[2] = 5'd0;  exps[2] = 32'd0;
        rds[3] = 5'd6;  exps[3] = 32'hFFFFFFFE;
        rds[4] = 5'd8;  exps[4] = 32'hF8000000;
        rds[5] = 5'd19; exps[5] = 32'h08000000;
        rds[6] = 5'd17; exps[6] = 32'd1;
        foreach (rds[i]) begin
            probe(rds[i], exps[i]);
            n_cmp++;
            if (beq !== 1'b1) begin
                n_bad++;
                $display("FAIL alu_directed x%0d: eq-probe beq=%b, required 1 (value %h)", rds[i], beq, exps[i]);
            end
        end
        probe(5'd18, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL alu_sltu x18: eq-probe beq=%b, required 1 (value 0)", beq);
        end
    endtask

    task automatic test_random_alu();
        logic [5:0]  op;
        logic [4:0]  r1, r2, rd, sh;
        logic [31:0] imm, res, a;
        logic [3:0]  strb, exp_flags;
        for (int r = 1; r < 32; r++) set_reg(5'(r), $urandom);
        set_reg(5'd12, 32'd1);
        for (int it = 0; it < 40; it++) begin
            op   = {1'($urandom), 5'($urandom_range(0, 16))};
            r1   = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            imm  = ($urandom_range(0, 3) == 0) ? m_rf[r1] : $urandom;
            strb = 4'($urandom);
            idle();
            alu_cntrl = op; read_reg_num1 = r1; read_reg_num2 = r2; write_reg_num = rd;
            imm_val = imm; shamt = sh; reg_write = 1'b1;
            {beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl} = strb;
            res = ref_alu(op, m_rf[r1], m_rf[r2], imm, sh);
            a   = m_rf[r1] + imm;
            exp_flags = strb & {4{res == 32'd1}};
            #1;
            n_cmp++;
            if ({beq, bneq, bgeq, blt} !== exp_flags) begin
                n_bad++;
                $display("FAIL rand_flags it%0d op=%h: flags=%b, required %b", it, op, {beq, bneq, bgeq, blt}, exp_flags);
            end
            n_cmp++;
            if (read_data_addr_dm !== a[4:0]) begin
                n_bad++;
                $display("FAIL rand_dm_idx it%0d: idx=%0d, required %0d", it, read_data_addr_dm, a[4:0]);
            end
            tick();
            model_wb(rd, res);
            probe(rd, m_rf[rd]);
            n_cmp++;
            if (beq !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_result it%0d op=%h x%0d: eq-probe beq=%b, required 1 (value %h)", it, op, rd, beq, m_rf[rd]);
            end
        end
    endtask

    task automatic test_memory();
        logic [4:0]  r1, r2, rd;
        logic [31:0] imm;
        set_reg(5'd2, 32'd10);
        set_reg(5'd11, 32'h5A5A0011);
        idle();
        alu_cntrl = 6'h21; read_reg_num2 = 5'd2; imm_val = 32'd3; sw = 1'b1;
        #1;
        n_cmp++;
        if (read_data_addr_dm !== 5'd3) begin
            n_bad++;
            $display("FAIL sw_index: idx=%0d, required 3", read_data_addr_dm);
        end
        do_sw(5'd0, 5'd2, 32'd3, 5'd11);
        probe(5'd11, 32'h5A5A0011);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_no_regwrite x11: eq-probe beq=%b, required 1 (value 5a5a0011)", beq);
        end
        do_lw(5'd0, 32'd3, 5'd4);
        do_lw(5'd0, 32'd35, 5'd13);
        probe(5'd4, 32'd10);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL lw x4: eq-probe beq=%b, required 1 (value 10)", beq);
        end
        probe(5'd13, 32'd10);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL lw_alias35 x13: eq-probe beq=%b, required 1 (value 10)", beq);
        end
        for (int it = 0; it < 12; it++) begin
            r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom); imm = $urandom;
            do_sw(r1, r2, imm, rd);
            r1 = 5'($urandom); rd = 5'($urandom); imm = 32'($urandom_range(0, 63)) - m_rf[r1];
            do_lw(r1, imm, rd);
            probe(rd, m_rf[rd]);
            n_cmp++;
            if (beq !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_lw it%0d x%0d: eq-probe beq=%b, required 1 (value %h)", it, rd, beq, m_rf[rd]);
            end
        end
    endtask

    task automatic test_branches();
        set_reg(5'd13, 32'd9);
        set_reg(5'd14, 32'd9);
        set_reg(5'd15, 32'hFFFFFFFE);
        set_reg(5'd16, 32'd1);
        idle();
        read_reg_num1 = 5'd13; read_reg_num2 = 5'd14; alu_cntrl = 6'h0B; beq_cntrl = 1'b1;
        #1;
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL br_beq: beq=%b, required 1", beq);
        end
        alu_cntrl = 6'h0C; beq_cntrl = 1'b0; bneq_cntrl = 1'b1;
        #1;
        n_cmp++;
        if (bneq !== 1'b0) begin
            n_bad++;
            $display("FAIL br_bneq: bneq=%b, required 0", bneq);
        end
        idle();
        read_reg_num1 = 5'd15; read_reg_num2 = 5'd16; alu_cntrl = 6'h0E; blt_cntrl = 1'b1;
        #1;
        n_cmp++;
        if ({beq, bneq, bgeq, blt} !== 4'b0001) begin
            n_bad++;
            $display("FAIL br_blt: flags=%b, required 0001", {beq, bneq, bgeq, blt});
        end
        alu_cntrl = 6'h0D; blt_cntrl = 1'b0; bgeq_cntrl = 1'b1;
        #1;
        n_cmp++;
        if (bgeq !== 1'b0) begin
            n_bad++;
            $display("FAIL br_bgeq: bgeq=%b, required 0", bgeq);
        end
    endtask

    task automatic test_wb_priority();
        idle();
        lui_cntrl = 1'b1; imm_val_lui = 32'h12345000; mem_to_reg = 1'b1;
        alu_cntrl = 6'h21; imm_val = 32'd77; reg_write = 1'b1; write_reg_num = 5'd20;
        tick();
        model_wb(5'd20, 32'h12345000);
        probe(5'd20, 32'h12345000);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL wb_lui x20: eq-probe beq=%b, required 1 (value 12345000)", beq);
        end
        idle();
        jump = 1'b1; return_address = 32'h40; lui_cntrl = 1'b1; imm_val_lui = 32'h12345000;
        mem_to_reg = 1'b1; reg_write = 1'b1; write_reg_num = 5'd21;
        tick();
        model_wb(5'd21, 32'h40);
        probe(5'd21, 32'h40);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL wb_jump x21: eq-probe beq=%b, required 1 (value 40)", beq);
        end
        idle();
        lui_cntrl = 1'b1; imm_val_lui = 32'hDEAD0000; write_reg_num = 5'd20;
        tick();
        probe(5'd20, 32'h12345000);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL wb_no_regwrite x20: eq-probe beq=%b, required 1 (value 12345000)", beq);
        end
    endtask

    task automatic test_reset_midrun();
        set_reg(5'd1, 32'h11111111);
        set_reg(5'd31, 32'hFFFF0000);
        set_reg(5'd2, 32'd10);
        do_sw(5'd0, 5'd2, 32'd3, 5'd0);
        idle();
        #2;
        reset = 1'b0;
        clear_model();
        probe(5'd1, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_async_clear x1: eq-probe beq=%b, required 1 (value 0)", beq);
        end
        idle();
        lui_cntrl = 1'b1; imm_val_lui = 32'h77770000; reg_write = 1'b1; write_reg_num = 5'd9;
        tick();
        idle();
        alu_cntrl = 6'h21; read_reg_num2 = 5'd31; imm_val = 32'd3; sw = 1'b1;
        tick();
        reset = 1'b1;
        probe(5'd9, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_write_lost x9: eq-probe beq=%b, required 1 (value 0)", beq);
        end
        probe(5'd31, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_clear x31: eq-probe beq=%b, required 1 (value 0)", beq);
        end
        do_lw(5'd0, 32'd3, 5'd4);
        probe(5'd4, 32'd0);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_dm_clear x4: eq-probe beq=%b, required 1 (value 0)", beq);
        end
        do_alu(6'h21, 5'd0, 5'd0, 5'd1, 32'd5, 5'd0);
        probe(5'd1, 32'd5);
        n_cmp++;
        if (beq !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_resume x1: eq-probe beq=%b, required 1 (value 5)", beq);
        end
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_random_alu();
        test_memory();
        test_branches();
        test_wb_priority();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
